// File: rtl/fetch_seq_if.sv
// Producer/consumer bundle between the fetch sequencer, program memory
// and the microcode decoder.
interface fetch_seq_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic [7:0]        insn;
  logic [7:0]        d1;
  logic [7:0]        d2;
  logic [7:0]        d3;
  logic [2:0]        is;
  logic              exec;
  logic [1:0]        len;
  logic              pc_lrc;
  logic              pc_ini;
  logic              pc_cub;
  logic [ADDR_W-1:0] jmp_addr;
  logic [ADDR_W-1:0] pc;
  logic              ovf;

  modport master (
    output mem_req, mem_addr, insn, d1, d2, d3, is, exec, pc, ovf,
    input  mem_ack, mem_data, len, pc_lrc, pc_ini, pc_cub, jmp_addr
  );

  modport slave (
    input  mem_req, mem_addr, insn, d1, d2, d3, is, exec, pc, ovf,
    output mem_ack, mem_data, len, pc_lrc, pc_ini, pc_cub, jmp_addr
  );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch and step sequencer: reads opcode plus up to three operand
// bytes over a req/ack bus, then steps the decoder through micro-steps 0..7.
module fetch_seq #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst,
  fetch_seq_if.master bus
);

  typedef enum logic [1:0] {FETCH, DECODE, OPERAND, EXEC} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        insn_q;
  logic [7:0]        d1_q;
  logic [7:0]        d2_q;
  logic [7:0]        d3_q;
  logic [2:0]        is_q;
  logic              exec_q;
  logic              req_q;
  logic              ovf_q;
  logic [1:0]        k;
  logic [1:0]        n;
  logic              take;

  // An ack only counts while our own request is outstanding.
  assign take = req_q && bus.mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= FETCH;
      pc_q   <= RESET_PC;
      insn_q <= 8'h00;
      d1_q   <= 8'h00;
      d2_q   <= 8'h00;
      d3_q   <= 8'h00;
      is_q   <= 3'd0;
      exec_q <= 1'b0;
      req_q  <= 1'b0;
      ovf_q  <= 1'b0;
      k      <= 2'd0;
      n      <= 2'd0;
    end else begin
      case (state)
        FETCH: begin
          // Only reset lands here with the request still low.
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (take) begin
            insn_q <= bus.mem_data;
            d1_q   <= 8'h00;
            d2_q   <= 8'h00;
            d3_q   <= 8'h00;
            pc_q   <= pc_q + ADDR_W'(1);
            k      <= 2'd0;
            req_q  <= 1'b0;
            state  <= DECODE;
          end
        end
        DECODE: begin
          if (bus.len == 2'd0) begin
            is_q   <= 3'd0;
            exec_q <= 1'b1;
            state  <= EXEC;
          end else begin
            n     <= bus.len;
            req_q <= 1'b1;
            state <= OPERAND;
          end
        end
        OPERAND: begin
          if (take) begin
            case (k)
              2'd0:    d1_q <= bus.mem_data;
              2'd1:    d2_q <= bus.mem_data;
              default: d3_q <= bus.mem_data;
            endcase
            pc_q <= pc_q + ADDR_W'(1);
            k    <= k + 2'd1;
            if ((k + 2'd1) == n) begin
              req_q  <= 1'b0;
              is_q   <= 3'd0;
              exec_q <= 1'b1;
              state  <= EXEC;
            end
          end
        end
        EXEC: begin
          if (bus.pc_lrc) begin
            pc_q   <= bus.jmp_addr;
            is_q   <= 3'd0;
            exec_q <= 1'b0;
            req_q  <= 1'b1;
            state  <= FETCH;
          end else if (bus.pc_ini) begin
            is_q   <= 3'd0;
            exec_q <= 1'b0;
            req_q  <= 1'b1;
            state  <= FETCH;
          end else begin
            if (bus.pc_cub) begin
              pc_q <= pc_q + ADDR_W'(1);
            end
            // Running off the last step aborts the instruction and sticks ovf.
            if (is_q == 3'd7) begin
              ovf_q  <= 1'b1;
              is_q   <= 3'd0;
              exec_q <= 1'b0;
              req_q  <= 1'b1;
              state  <= FETCH;
            end else begin
              is_q <= is_q + 3'd1;
            end
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = pc_q;
  assign bus.insn     = insn_q;
  assign bus.d1       = d1_q;
  assign bus.d2       = d2_q;
  assign bus.d3       = d3_q;
  assign bus.is       = is_q;
  assign bus.exec     = exec_q;
  assign bus.pc       = pc_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: memory responder, decoder strobes and a
// scoreboard of expected instruction contents popped on each EXEC entry.
module tb_fetch_seq;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic rst6;

  always #5 clk = ~clk;

  fetch_seq_if #(.ADDR_W(ADDR_W)) b ();
  fetch_seq_if #(.ADDR_W(ADDR_W)) b6 ();

  fetch_seq #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  fetch_seq #(.ADDR_W(ADDR_W), .RESET_PC(16'hFFFF)) dut6 (
    .clk(clk),
    .rst(rst6),
    .bus(b6)
  );

  logic [7:0] mem [0:65535];
  int ack_delay = 0;
  int wait_cnt  = 0;
  int checks    = 0;
  int failures  = 0;

  typedef struct {
    string      tag;
    logic [7:0] insn;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
    logic [15:0] pc;
    int         lat;
  } exp_t;

  exp_t sb[$];

  // Memory model for the main DUT: acks after ack_delay waiting cycles.
  always @(negedge clk) begin
    if (b.mem_req === 1'b1) begin
      if (wait_cnt >= ack_delay) begin
        b.mem_ack  = 1'b1;
        b.mem_data = mem[b.mem_addr];
        wait_cnt   = 0;
      end else begin
        b.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      b.mem_ack = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit sel, input string tag, input logic [15:0] addr,
                                input logic [7:0] op, input int nops, input logic [7:0] o1,
                                input logic [7:0] o2, input logic [7:0] o3, input int lat);
    exp_t e;
    mem[addr] = op;
    if (nops >= 1) mem[addr + 16'd1] = o1;
    if (nops >= 2) mem[addr + 16'd2] = o2;
    if (nops >= 3) mem[addr + 16'd3] = o3;
    e.tag  = tag;
    e.insn = op;
    e.d1   = (nops >= 1) ? o1 : 8'h00;
    e.d2   = (nops >= 2) ? o2 : 8'h00;
    e.d3   = (nops >= 3) ? o3 : 8'h00;
    e.pc   = addr + 16'd1 + 16'(nops);
    e.lat  = lat;
    sb.push_back(e);
    if (sel) b6.len = 2'(nops);
    else     b.len  = 2'(nops);
  endtask

  // start_n counts negedges since the posedge that entered FETCH.
  task automatic check_output(input bit sel, input int start_n);
    int   n = start_n;
    exp_t e;
    while (((sel ? b6.exec : b.exec) !== 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("exec_reached", sel ? b6.exec : b.exec, 1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".insn"}, sel ? b6.insn : b.insn, e.insn);
      check({e.tag, ".d1"},   sel ? b6.d1   : b.d1,   e.d1);
      check({e.tag, ".d2"},   sel ? b6.d2   : b.d2,   e.d2);
      check({e.tag, ".d3"},   sel ? b6.d3   : b.d3,   e.d3);
      check({e.tag, ".pc"},   sel ? b6.pc   : b.pc,   e.pc);
      check({e.tag, ".is"},   sel ? b6.is   : b.is,   0);
      check({e.tag, ".lat"},  n - 1,                  e.lat);
    end
  endtask

  initial begin
    rst = 1'b0; rst6 = 1'b0;
    b.len = 2'd0; b.pc_lrc = 1'b0; b.pc_ini = 1'b0; b.pc_cub = 1'b0; b.jmp_addr = '0;
    b6.len = 2'd0; b6.pc_lrc = 1'b0; b6.pc_ini = 1'b0; b6.pc_cub = 1'b0; b6.jmp_addr = '0;
    b6.mem_ack = 1'b0; b6.mem_data = 8'h00;

    // Reset state, then a len=0 instruction ended by pc_ini at step 2.
    apply_stimulus(0, "t1", 16'h0000, 8'h10, 0, 8'h00, 8'h00, 8'h00, 2);
    repeat (2) @(negedge clk);
    check("rst.mem_req", b.mem_req, 0);
    check("rst.pc", b.pc, 0);
    check("rst.exec", b.exec, 0);
    check("rst.is", b.is, 0);
    check("rst.insn", b.insn, 0);
    check("rst.ovf", b.ovf, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t1.req", b.mem_req, 1);
    check("t1.addr", b.mem_addr, 16'h0000);
    check_output(0, 1);
    @(negedge clk);
    check("t1.is1", b.is, 1);
    @(negedge clk);
    check("t1.is2", b.is, 2);
    check("t1.exec2", b.exec, 1);
    apply_stimulus(0, "t2", 16'h0001, 8'h20, 3, 8'hAA, 8'hBB, 8'hCC, 5);
    b.pc_ini = 1'b1;
    @(negedge clk);
    b.pc_ini = 1'b0;
    check("t1.next_addr", b.mem_addr, 16'h0001);
    check("t1.next_req", b.mem_req, 1);
    check("t1.exec_off", b.exec, 0);

    // Three operands, zero-wait memory.
    check_output(0, 1);

    // Slow memory, one operand, then pc_lrc at step 1.
    apply_stimulus(0, "t3", 16'h0010, 8'h30, 1, 8'h5A, 8'h00, 8'h00, 9);
    ack_delay = 3;
    b.pc_lrc = 1'b1; b.jmp_addr = 16'h0010;
    @(negedge clk);
    b.pc_lrc = 1'b0;
    check("t3.addr0", b.mem_addr, 16'h0010);
    repeat (3) begin
      @(negedge clk);
      check("t3.hold0", b.mem_addr, 16'h0010);
      check("t3.req0", b.mem_req, 1);
    end
    @(negedge clk);
    check("t3.decode_req", b.mem_req, 0);
    repeat (4) begin
      @(negedge clk);
      check("t3.hold1", b.mem_addr, 16'h0011);
      check("t3.req1", b.mem_req, 1);
    end
    check_output(0, 9);
    ack_delay = 0;
    @(negedge clk);
    check("t3.is1", b.is, 1);
    apply_stimulus(0, "t4a", 16'h1234, 8'h40, 0, 8'h00, 8'h00, 8'h00, 2);
    b.pc_lrc = 1'b1; b.jmp_addr = 16'h1234;
    @(negedge clk);
    b.pc_lrc = 1'b0;
    check("t3.jmp_addr", b.mem_addr, 16'h1234);
    check("t3.jmp_is", b.is, 0);
    check("t3.jmp_req", b.mem_req, 1);
    check_output(0, 1);

    // pc_lrc beats pc_ini; pc_cub at step 3.
    apply_stimulus(0, "t4b", 16'h2000, 8'h41, 2, 8'h01, 8'h02, 8'h00, 4);
    b.pc_lrc = 1'b1; b.pc_ini = 1'b1; b.jmp_addr = 16'h2000;
    @(negedge clk);
    b.pc_lrc = 1'b0; b.pc_ini = 1'b0;
    check("t4.prio_pc", b.pc, 16'h2000);
    check_output(0, 1);
    repeat (3) @(negedge clk);
    check("t4.is3", b.is, 3);
    b.pc_cub = 1'b1;
    @(negedge clk);
    b.pc_cub = 1'b0;
    check("t4.cub_pc", b.pc, 16'h2004);
    check("t4.cub_is", b.is, 4);

    // Overflow: eight idle steps, pc_cub on the last one.
    apply_stimulus(0, "t5", 16'h2004, 8'h50, 0, 8'h00, 8'h00, 8'h00, 2);
    b.pc_ini = 1'b1;
    @(negedge clk);
    b.pc_ini = 1'b0;
    check_output(0, 1);
    for (int i = 0; i < 8; i++) begin
      check("t5.is_seq", b.is, i);
      check("t5.exec", b.exec, 1);
      if (i == 7) begin
        check("t5.ovf_before", b.ovf, 0);
        b.pc_cub = 1'b1;
        apply_stimulus(0, "t5b", 16'h2006, 8'h60, 1, 8'h77, 8'h00, 8'h00, 3);
      end
      @(negedge clk);
    end
    b.pc_cub = 1'b0;
    check("t5.ovf", b.ovf, 1);
    check("t5.exec_off", b.exec, 0);
    check("t5.is_zero", b.is, 0);
    check("t5.refetch_addr", b.mem_addr, 16'h2006);
    check("t5.refetch_req", b.mem_req, 1);
    check_output(0, 1);
    check("t5.ovf_sticky", b.ovf, 1);
    b.pc_ini = 1'b1;
    @(negedge clk);
    b.pc_ini = 1'b0;
    check("t5.ovf_sticky2", b.ovf, 1);
    rst = 1'b0;
    #1;
    check("t5.ovf_cleared", b.ovf, 0);
    check("t5.rst_pc", b.pc, 16'h0000);

    // Wrap from RESET_PC=0xFFFF, then reset mid-operand with a late ack.
    apply_stimulus(1, "t6", 16'hFFFF, 8'h90, 1, 8'h91, 8'h00, 8'h00, 3);
    @(negedge clk);
    rst6 = 1'b1;
    @(negedge clk);
    check("t6.req", b6.mem_req, 1);
    check("t6.addr", b6.mem_addr, 16'hFFFF);
    b6.mem_ack = 1'b1; b6.mem_data = 8'h90;
    @(negedge clk);
    b6.mem_ack = 1'b0;
    check("t6.wrap_pc", b6.pc, 16'h0000);
    check("t6.decode_req", b6.mem_req, 0);
    @(negedge clk);
    check("t6.op_addr", b6.mem_addr, 16'h0000);
    b6.mem_ack = 1'b1; b6.mem_data = 8'h91;
    @(negedge clk);
    b6.mem_ack = 1'b0;
    check_output(1, 4);
    b6.pc_ini = 1'b1; b6.len = 2'd2;
    @(negedge clk);
    b6.pc_ini = 1'b0;
    check("t6.next_addr", b6.mem_addr, 16'h0001);
    b6.mem_ack = 1'b1; b6.mem_data = 8'h92;
    @(negedge clk);
    b6.mem_ack = 1'b0;
    @(negedge clk);
    check("t6.operand_req", b6.mem_req, 1);
    check("t6.operand_addr", b6.mem_addr, 16'h0002);
    rst6 = 1'b0;
    #1;
    check("t6.rst_req", b6.mem_req, 0);
    check("t6.rst_pc", b6.pc, 16'hFFFF);
    check("t6.rst_exec", b6.exec, 0);
    b6.mem_ack = 1'b1; b6.mem_data = 8'hEE;
    @(negedge clk);
    rst6 = 1'b1;
    @(negedge clk);
    check("t6.late_req", b6.mem_req, 1);
    check("t6.late_pc", b6.pc, 16'hFFFF);
    check("t6.late_insn", b6.insn, 8'h00);
    b6.mem_ack = 1'b0;
    @(negedge clk);
    check("t6.still_fetch_addr", b6.mem_addr, 16'hFFFF);
    check("t6.still_fetch_insn", b6.insn, 8'h00);
    check("sb.drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
